// File: rtl/b_history_trainer_pkg.sv
// Shared types for the B-branch history trainer: widths, FSM states,
// pending-entry layout and the saturating weight step.
package b_history_trainer_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int LANES     = 4;
  localparam int WEIGHT_W  = 8;
  localparam int GHR_W     = 20;
  localparam int NWT       = 9;

  typedef enum logic {
    NORMAL = 1'b0,
    B      = 1'b1
  } br_type_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_TRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0]       lane;
    logic             pred_dir;
    logic [GHR_W-1:0] ghr_snap;
  } entry_t;

  localparam logic [WEIGHT_W-1:0] W_MAX =
    {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] W_MIN =
    {1'b1, {(WEIGHT_W-1){1'b0}}};

  function automatic logic [WEIGHT_W-1:0] sat_step(
    input logic [WEIGHT_W-1:0] w,
    input logic                up
  );
    if (up)
      return (w == W_MAX) ? w : w + 1'b1;
    else
      return (w == W_MIN) ? w : w - 1'b1;
  endfunction

endpackage

// File: rtl/b_pending_fifo.sv
// In-order pending-B FIFO: up to LANES pushes and one pop per cycle,
// synchronous clear on mispredict, occupancy output.
module b_pending_fifo
  import b_history_trainer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [2:0]            push_n,
  input  entry_t [LANES-1:0]    push_data,
  input  logic                  pop,
  output entry_t                head,
  output logic [PW:0]           occ
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr;
  logic [PW-1:0] rd;

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < LANES; i++) begin
        if (3'(i) < push_n)
          mem[wr + PW'(i)] <= push_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr  <= '0;
      rd  <= '0;
      occ <= '0;
    end else if (clr) begin
      wr  <= '0;
      rd  <= '0;
      occ <= '0;
    end else begin
      wr  <= wr + PW'(push_n);
      rd  <= rd + PW'(pop);
      occ <= occ + (PW+1)'(push_n)
                 - (PW+1)'(pop);
    end
  end

  assign head = mem[rd];

endmodule

// File: rtl/b_history_trainer.sv
// B-history trainer: pending FIFO, speculative/architectural GHR and
// 4x9 perceptron training FSM. B_TRAIN_STATS_EN adds fire/mispredict counters.
module b_history_trainer
  import b_history_trainer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_predValid,
  input  logic [2:0]   i_passBNum_3,
  input  logic         i_predictGotJ,
  input  logic         i_gotErr,
  output logic         o_pushReady,
  input  logic         i_resolveValid,
  input  logic         i_resolveTaken,
  output logic         o_resolveReady,
  output logic         o_flush,
  output logic [19:0]  o_ghr_20,
  output logic [287:0] o_weights_288,
  output logic [7:0]   o_pendingB_8
`ifdef B_TRAIN_STATS_EN
  ,
  output logic [31:0]  o_resolvedCnt_32,
  output logic [31:0]  o_mispredCnt_32
`endif
);

  localparam int PW = $clog2(DEPTH);

  state_e state_q, state_d;
  logic [3:0]       k_q;
  logic [1:0]       tr_lane;
  logic [GHR_W-1:0] tr_snap;
  logic             tr_taken;
  logic [GHR_W-1:0] spec_ghr;
  logic [GHR_W-1:0] arch_ghr;
  logic             flush_q;
  logic [LANES-1:0][NWT-1:0][WEIGHT_W-1:0] weights;

  entry_t             head;
  entry_t [LANES-1:0] push_data;
  logic [PW:0]        occ;
  logic [2:0]         n_eff;
  logic [2:0]         push_cnt;
  logic               push_ok;
  logic               fire;
  logic               mis;
  logic               up;
  logic [GHR_W-1:0]   arch_next;

  assign n_eff = (i_passBNum_3 > 3'd4) ? 3'd4
                                       : i_passBNum_3;

  assign o_pushReady =
    (int'(occ) + LANES) <= DEPTH;
  assign o_resolveReady =
    (state_q == S_IDLE) && (occ != '0);

  assign push_ok = i_predValid & ~i_gotErr
                 & o_pushReady & (n_eff != 3'd0);
  assign push_cnt = push_ok ? n_eff : 3'd0;

  assign fire = i_resolveValid & o_resolveReady;
  assign mis  = fire
              & (i_resolveTaken != head.pred_dir);
  assign arch_next =
    {arch_ghr[GHR_W-2:0], i_resolveTaken};

  // Only the last consumed B of a group can carry a taken prediction.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      push_data[i].lane     = 2'(i);
      push_data[i].pred_dir = i_predictGotJ
        & (3'(i) == n_eff - 3'd1);
      push_data[i].ghr_snap = spec_ghr;
    end
  end

  b_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clr       (mis),
    .push_n    (push_cnt),
    .push_data (push_data),
    .pop       (fire),
    .head      (head),
    .occ       (occ)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (mis) state_d = S_TRAIN;
      S_TRAIN:
        if (k_q == 4'd8) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // k==8 is the bias, which tracks the outcome alone.
  assign up = (k_q == 4'd8)
            ? tr_taken
            : (tr_taken == tr_snap[5'(k_q)]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k_q      <= '0;
      tr_lane  <= '0;
      tr_snap  <= '0;
      tr_taken <= 1'b0;
      spec_ghr <= '0;
      arch_ghr <= '0;
      flush_q  <= 1'b0;
      weights  <= '0;
    end else begin
      flush_q <= mis;
      if (fire)
        arch_ghr <= arch_next;
      if (mis)
        spec_ghr <= arch_next;
      else if (push_ok)
        spec_ghr <= (spec_ghr << n_eff)
                  | GHR_W'(i_predictGotJ);
      if (mis) begin
        tr_lane  <= head.lane;
        tr_snap  <= head.ghr_snap;
        tr_taken <= i_resolveTaken;
        k_q      <= '0;
      end else if (state_q == S_TRAIN) begin
        k_q <= k_q + 4'd1;
        weights[tr_lane][k_q] <=
          sat_step(weights[tr_lane][k_q], up);
      end
    end
  end

`ifdef B_TRAIN_STATS_EN
  logic [31:0] res_cnt;
  logic [31:0] mis_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_cnt <= '0;
      mis_cnt <= '0;
    end else begin
      if (fire) res_cnt <= res_cnt + 32'd1;
      if (mis)  mis_cnt <= mis_cnt + 32'd1;
    end
  end

  assign o_resolvedCnt_32 = res_cnt;
  assign o_mispredCnt_32  = mis_cnt;
`endif

  assign o_flush       = flush_q;
  assign o_ghr_20      = spec_ghr;
  assign o_weights_288 = weights;
  assign o_pendingB_8  = 8'(occ);

endmodule
